// File: rtl/e203_exu_longp_wbck_src.sv
// Long-pipe write-back source: holds LSU and MULDIV completions in one-entry
// registers and releases them strictly in OITF order as a valid/ready stream.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   lsu_i_* / div_i_*        completion inputs (valid/ready, data, flags, tag)
//   oitf_*                   OITF head view (empty, tag, rd index/wen/fpu)
//   oitf_ret_ena             pops the OITF head when its entry retires
//   longp_wbck_o_*           write-back request toward the final arbiter
module e203_exu_longp_wbck_src #(
    parameter int XLEN    = 32,
    parameter int FLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int ITAG_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lsu_i_valid,
    output logic               lsu_i_ready,
    input  logic [FLEN-1:0]    lsu_i_wdat,
    input  logic [ITAG_W-1:0]  lsu_i_itag,
    input  logic               div_i_valid,
    output logic               div_i_ready,
    input  logic [FLEN-1:0]    div_i_wdat,
    input  logic [4:0]         div_i_flags,
    input  logic [ITAG_W-1:0]  div_i_itag,
    input  logic               oitf_empty,
    input  logic [ITAG_W-1:0]  oitf_ret_ptr,
    input  logic [RFIDX_W-1:0] oitf_ret_rdidx,
    input  logic               oitf_ret_rdwen,
    input  logic               oitf_ret_rdfpu,
    output logic               oitf_ret_ena,
    output logic               longp_wbck_o_valid,
    input  logic               longp_wbck_o_ready,
    output logic [FLEN-1:0]    longp_wbck_o_wdat,
    output logic [4:0]         longp_wbck_o_flags,
    output logic [RFIDX_W-1:0] longp_wbck_o_rdidx,
    output logic               longp_wbck_o_rdfpu
);

    if (FLEN < XLEN) begin : g_bad_flen
        $error("FLEN must be at least XLEN");
    end

    logic              lsu_vld_q, lsu_vld_d;
    logic [FLEN-1:0]   lsu_wdat_q, lsu_wdat_d;
    logic [ITAG_W-1:0] lsu_itag_q, lsu_itag_d;

    logic              div_vld_q, div_vld_d;
    logic [FLEN-1:0]   div_wdat_q, div_wdat_d;
    logic [4:0]        div_flags_q, div_flags_d;
    logic [ITAG_W-1:0] div_itag_q, div_itag_d;

    logic m_lsu, m_div;
    logic sel_lsu, sel_div, sel_vld;
    logic ret_lsu, ret_div;

    always_comb begin
        // Outputs are forced idle while reset is applied, whatever the holds contain.
        m_lsu   = ~rst & lsu_vld_q & ~oitf_empty & (lsu_itag_q == oitf_ret_ptr);
        m_div   = ~rst & div_vld_q & ~oitf_empty & (div_itag_q == oitf_ret_ptr);
        sel_lsu = m_lsu;
        sel_div = ~m_lsu & m_div;
        sel_vld = m_lsu | m_div;

        longp_wbck_o_valid = sel_vld & oitf_ret_rdwen;
        longp_wbck_o_wdat  = '0;
        longp_wbck_o_flags = '0;
        longp_wbck_o_rdidx = '0;
        longp_wbck_o_rdfpu = 1'b0;
        if (sel_lsu) begin
            longp_wbck_o_wdat = lsu_wdat_q;
        end else if (sel_div) begin
            longp_wbck_o_wdat  = div_wdat_q;
            longp_wbck_o_flags = div_flags_q;
        end
        if (sel_vld) begin
            longp_wbck_o_rdidx = oitf_ret_rdidx;
            longp_wbck_o_rdfpu = oitf_ret_rdfpu;
        end

        // No-write entries retire immediately; others wait for the arbiter.
        oitf_ret_ena = sel_vld & (oitf_ret_rdwen ? longp_wbck_o_ready : 1'b1);
        ret_lsu      = oitf_ret_ena & sel_lsu;
        ret_div      = oitf_ret_ena & sel_div;

        lsu_i_ready = rst | ~lsu_vld_q | ret_lsu;
        div_i_ready = rst | ~div_vld_q | ret_div;

        lsu_vld_d   = lsu_vld_q;
        lsu_wdat_d  = lsu_wdat_q;
        lsu_itag_d  = lsu_itag_q;
        div_vld_d   = div_vld_q;
        div_wdat_d  = div_wdat_q;
        div_flags_d = div_flags_q;
        div_itag_d  = div_itag_q;

        if (ret_lsu) lsu_vld_d = 1'b0;
        if (ret_div) div_vld_d = 1'b0;
        // A load in the retire cycle overrides the clear.
        if (lsu_i_valid & lsu_i_ready) begin
            lsu_vld_d  = 1'b1;
            lsu_wdat_d = lsu_i_wdat;
            lsu_itag_d = lsu_i_itag;
        end
        if (div_i_valid & div_i_ready) begin
            div_vld_d   = 1'b1;
            div_wdat_d  = div_i_wdat;
            div_flags_d = div_i_flags;
            div_itag_d  = div_i_itag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_vld_q   <= 1'b0;
            lsu_wdat_q  <= '0;
            lsu_itag_q  <= '0;
            div_vld_q   <= 1'b0;
            div_wdat_q  <= '0;
            div_flags_q <= '0;
            div_itag_q  <= '0;
        end else begin
            lsu_vld_q   <= lsu_vld_d;
            lsu_wdat_q  <= lsu_wdat_d;
            lsu_itag_q  <= lsu_itag_d;
            div_vld_q   <= div_vld_d;
            div_wdat_q  <= div_wdat_d;
            div_flags_q <= div_flags_d;
            div_itag_q  <= div_itag_d;
        end
    end

    // OITF tags are unique, so both holds can never match the head together.
    a_one_head_match: assert property (
        @(posedge clk) disable iff (rst) !(m_lsu && m_div)
    );

endmodule

// File: tb/tb_e203_exu_longp_wbck_src.sv
// Testbench for e203_exu_longp_wbck_src: OITF ring model plus
// a write-back scoreboard checked in OITF order.
module tb_e203_exu_longp_wbck_src;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_i_valid;
    logic        lsu_i_ready;
    logic [31:0] lsu_i_wdat;
    logic [1:0]  lsu_i_itag;
    logic        div_i_valid;
    logic        div_i_ready;
    logic [31:0] div_i_wdat;
    logic [4:0]  div_i_flags;
    logic [1:0]  div_i_itag;
    logic        oitf_empty;
    logic [1:0]  oitf_ret_ptr;
    logic [4:0]  oitf_ret_rdidx;
    logic        oitf_ret_rdwen;
    logic        oitf_ret_rdfpu;
    logic        oitf_ret_ena;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_wdat;
    logic [4:0]  o_flags;
    logic [4:0]  o_rdidx;
    logic        o_rdfpu;

    always #5 clk = ~clk;

    e203_exu_longp_wbck_src dut (
        .clk                (clk),
        .rst                (rst),
        .lsu_i_valid        (lsu_i_valid),
        .lsu_i_ready        (lsu_i_ready),
        .lsu_i_wdat         (lsu_i_wdat),
        .lsu_i_itag         (lsu_i_itag),
        .div_i_valid        (div_i_valid),
        .div_i_ready        (div_i_ready),
        .div_i_wdat         (div_i_wdat),
        .div_i_flags        (div_i_flags),
        .div_i_itag         (div_i_itag),
        .oitf_empty         (oitf_empty),
        .oitf_ret_ptr       (oitf_ret_ptr),
        .oitf_ret_rdidx     (oitf_ret_rdidx),
        .oitf_ret_rdwen     (oitf_ret_rdwen),
        .oitf_ret_rdfpu     (oitf_ret_rdfpu),
        .oitf_ret_ena       (oitf_ret_ena),
        .longp_wbck_o_valid (o_valid),
        .longp_wbck_o_ready (o_ready),
        .longp_wbck_o_wdat  (o_wdat),
        .longp_wbck_o_flags (o_flags),
        .longp_wbck_o_rdidx (o_rdidx),
        .longp_wbck_o_rdfpu (o_rdfpu)
    );

    typedef struct {
        logic [31:0] wdat;
        logic [4:0]  flags;
        logic [4:0]  rdidx;
        logic        rdfpu;
    } wb_t;

    wb_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int ret_seen = 0;

    // OITF model: alloc side owned by stimulus, retire side by the DUT pop.
    logic [7:0]  alloc_cnt;
    logic [7:0]  ret_cnt;
    logic [4:0]  ent_rdidx [4];
    logic        ent_rdwen [4];
    logic        ent_rdfpu [4];
    logic [31:0] ent_wdat  [4];
    logic [4:0]  ent_flags [4];

    assign oitf_empty     = (alloc_cnt == ret_cnt);
    assign oitf_ret_ptr   = ret_cnt[1:0];
    assign oitf_ret_rdidx = ent_rdidx[ret_cnt[1:0]];
    assign oitf_ret_rdwen = ent_rdwen[ret_cnt[1:0]];
    assign oitf_ret_rdfpu = ent_rdfpu[ret_cnt[1:0]];

    always @(posedge clk) begin
        if (rst)               ret_cnt <= '0;
        else if (oitf_ret_ena) ret_cnt <= ret_cnt + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write-back monitor: every accepted request must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (oitf_ret_ena) ret_seen++;
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    chk("wb_wdat",  o_wdat, e.wdat);
                    chk("wb_flags", {27'd0, o_flags}, {27'd0, e.flags});
                    chk("wb_rdidx", {27'd0, o_rdidx}, {27'd0, e.rdidx});
                    chk("wb_rdfpu", {31'd0, o_rdfpu}, {31'd0, e.rdfpu});
                end
            end
            if (o_valid && !o_ready)
                chk("bp_no_ret", {31'd0, oitf_ret_ena}, 32'd0);
        end
    end

    task automatic alloc(input logic [4:0] rdidx, input logic rdwen,
                         input logic rdfpu, input logic [31:0] wdat,
                         input logic [4:0] flags, input logic is_lsu,
                         output logic [1:0] tag);
        wb_t e;
        tag = alloc_cnt[1:0];
        ent_rdidx[tag] = rdidx;
        ent_rdwen[tag] = rdwen;
        ent_rdfpu[tag] = rdfpu;
        ent_wdat[tag]  = wdat;
        ent_flags[tag] = flags;
        alloc_cnt = alloc_cnt + 8'd1;
        if (rdwen) begin
            e.wdat  = wdat;
            e.flags = is_lsu ? 5'd0 : flags;
            e.rdidx = rdidx;
            e.rdfpu = rdfpu;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_lsu(input logic [1:0] t);
        int  n = 0;
        bit  acc = 0;
        lsu_i_valid = 1'b1;
        lsu_i_wdat  = ent_wdat[t];
        lsu_i_itag  = t;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = lsu_i_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("lsu_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_div(input logic [1:0] t);
        int  n = 0;
        bit  acc = 0;
        div_i_valid = 1'b1;
        div_i_wdat  = ent_wdat[t];
        div_i_flags = ent_flags[t];
        div_i_itag  = t;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = div_i_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("div_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (alloc_cnt != ret_cnt && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, {31'd0, alloc_cnt == ret_cnt}, 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "_ret"},   {31'd0, oitf_ret_ena}, 32'd0);
        chk({tag, "_wdat"},  o_wdat, 32'd0);
        chk({tag, "_rdidx"}, {27'd0, o_rdidx}, 32'd0);
        chk({tag, "_lrdy"},  {31'd0, lsu_i_ready}, 32'd1);
        chk({tag, "_drdy"},  {31'd0, div_i_ready}, 32'd1);
    endtask

    initial begin
        logic [1:0] ta, tb, tc;
        int r0;
        alloc_cnt   = '0;
        for (int i = 0; i < 4; i++) begin
            ent_rdidx[i] = '0;
            ent_rdwen[i] = 1'b0;
            ent_rdfpu[i] = 1'b0;
            ent_wdat[i]  = '0;
            ent_flags[i] = '0;
        end
        rst         = 1'b1;
        lsu_i_valid = 1'b1;
        lsu_i_wdat  = 32'hdead_beef;
        lsu_i_itag  = 2'd0;
        div_i_valid = 1'b0;
        div_i_wdat  = '0;
        div_i_flags = '0;
        div_i_itag  = '0;
        o_ready     = 1'b1;

        // 1: reset with lsu valid, then first accept
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        alloc(5'd3, 1'b1, 1'b0, 32'hA5A5_0001, 5'd0, 1'b1, ta);
        lsu_i_wdat = 32'hA5A5_0001;
        lsu_i_itag = ta;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, o_valid}, 32'd0);
        @(posedge clk);
        #1;
        lsu_i_valid = 1'b0;
        @(negedge clk);
        chk("first_valid", {31'd0, o_valid}, 32'd1);
        @(posedge clk);
        #1;
        drain("t1_drain");

        // 2: out-of-order completion released in OITF order
        r0 = ret_seen;
        alloc(5'd5, 1'b1, 1'b0, 32'h0000_1234, 5'h11, 1'b0, ta);
        alloc(5'd7, 1'b1, 1'b1, 32'h5555_0007, 5'd0, 1'b1, tb);
        send_lsu(tb);
        lsu_i_valid = 1'b0;
        @(negedge clk);
        chk("t2_hold_valid", {31'd0, o_valid}, 32'd0);
        chk("t2_lsu_stall", {31'd0, lsu_i_ready}, 32'd0);
        @(posedge clk);
        #1;
        send_div(ta);
        div_i_valid = 1'b0;
        drain("t2_drain");
        chk("t2_ret_pulses", ret_seen - r0, 32'd2);

        // 3: back-pressure
        o_ready = 1'b0;
        alloc(5'd9, 1'b1, 1'b0, 32'hCAFE_0009, 5'd0, 1'b1, ta);
        send_lsu(ta);
        lsu_i_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_valid", {31'd0, o_valid}, 32'd1);
            chk("t3_wdat", o_wdat, 32'hCAFE_0009);
            chk("t3_rdidx", {27'd0, o_rdidx}, 32'd9);
            chk("t3_lrdy", {31'd0, lsu_i_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        o_ready = 1'b1;
        @(negedge clk);
        chk("t3_ret", {31'd0, oitf_ret_ena}, 32'd1);
        @(posedge clk);
        #1;
        drain("t3_drain");

        // 4: no-write entry retires silently
        alloc(5'd4, 1'b0, 1'b0, 32'h7777_0004, 5'h3, 1'b0, ta);
        send_div(ta);
        div_i_valid = 1'b0;
        @(negedge clk);
        chk("t4_valid", {31'd0, o_valid}, 32'd0);
        chk("t4_ret", {31'd0, oitf_ret_ena}, 32'd1);
        @(posedge clk);
        #1;
        drain("t4_drain");

        // 5: back-to-back LSU completions
        alloc(5'd10, 1'b1, 1'b0, 32'h1000_0000, 5'd0, 1'b1, ta);
        alloc(5'd11, 1'b1, 1'b1, 32'h1000_0001, 5'd0, 1'b1, tb);
        alloc(5'd12, 1'b1, 1'b0, 32'h1000_0002, 5'd0, 1'b1, tc);
        for (int i = 0; i < 3; i++) begin
            logic [1:0] t;
            t = (i == 0) ? ta : (i == 1) ? tb : tc;
            lsu_i_valid = 1'b1;
            lsu_i_wdat  = ent_wdat[t];
            lsu_i_itag  = t;
            @(negedge clk);
            chk("t5_lrdy", {31'd0, lsu_i_ready}, 32'd1);
            if (i > 0) chk("t5_valid", {31'd0, o_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        lsu_i_valid = 1'b0;
        drain("t5_drain");

        // 6: reset with both holds occupied
        o_ready = 1'b0;
        alloc(5'd1, 1'b1, 1'b0, 32'hBBBB_0000, 5'd0, 1'b1, ta);
        alloc(5'd2, 1'b1, 1'b0, 32'hBBBB_0001, 5'h5, 1'b0, tb);
        send_lsu(ta);
        lsu_i_valid = 1'b0;
        send_div(tb);
        div_i_valid = 1'b0;
        @(negedge clk);
        chk("t6_valid", {31'd0, o_valid}, 32'd1);
        chk("t6_drdy", {31'd0, div_i_ready}, 32'd0);
        chk("t6_pending", exp_q.size(), 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        alloc_cnt = '0;
        exp_q.delete();
        @(negedge clk);
        chk_idle("t6_in_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        o_ready = 1'b1;
        @(negedge clk);
        chk_idle("t6_after");
        @(posedge clk);
        #1;
        alloc(5'd6, 1'b1, 1'b0, 32'h0BAD_F00D, 5'h1, 1'b0, ta);
        send_div(ta);
        div_i_valid = 1'b0;
        drain("t6_drain");
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
